tag_fifo_mc: RTL and testbench
==============================

# tag_fifo_mc

Multi-channel, parametrised tag FIFO: NUM_CH independent circular queues of DATA_WIDTH-bit tags, each 2**INDEX_BITS deep, behind one shared push port and one shared pop port, each port steered by a channel index. It replaces the single-queue tag FIFO in the cache free-tag path when several requestors need separate tag pools. New over the single-queue version:
- per-channel occupancy and almost-full/almost-empty thresholds;
- push-on-full when paired with a same-channel pop;
- synchronous flush;
- sticky overflow/underflow error flags.

## Interface
Parameters:
- NUM_CH, 4, number of channels (≥1); CH_BITS = max(1, $clog2(NUM_CH))
- INDEX_BITS, 3, log2 of per-channel depth; DEPTH = 2**INDEX_BITS
- DATA_WIDTH, 256, tag width
- AFULL_THRESH, 6, almost_full[c] asserted when count[c] ≥ this value
- AEMPTY_THRESH, 1, almost_empty[c] asserted when count[c] ≤ this value

Ports (widths use the parameter names above):
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  when low, no state changes (flush and err_clear included)
- flush  in  1  synchronous empty of all channels
- err_clear  in  1  clears both sticky error flags
- push  in  1  push request
- push_ch  in  CH_BITS  target channel of push
- push_tag  in  DATA_WIDTH  tag to enqueue
- push_ready  out  1  combinational: push would be accepted this cycle
- pop  in  1  pop request
- pop_ch  in  CH_BITS  channel to pop / observe
- pop_valid  out  1  head of pop_ch holds a tag (!empty[pop_ch])
- pop_tag  out  DATA_WIDTH  head tag of pop_ch; all-zero when pop_valid=0
- full, empty, almost_full, almost_empty  out  NUM_CH  per-channel status, bit c = channel c
- count  out  NUM_CH*(INDEX_BITS+1)  per-channel occupancy, channel c at bits [c*(INDEX_BITS+1) +: INDEX_BITS+1]
- overflow_err, underflow_err  out  1  sticky error flags

## Operation
**Storage and counters**
- Per channel: head_ptr and tail_ptr (INDEX_BITS wide, wrap modulo DEPTH), cnt (INDEX_BITS+1 wide, 0..DEPTH).
- Storage is not reset; only pointers and counts are.
- full[c] = (cnt==DEPTH); empty[c] = (cnt==0); thresholds as under Parameters.

**Accept rules** (all require enable=1 and flush=0)
- pop_acc = pop && !empty[pop_ch].
- push_acc = push && (!full[push_ch] || (pop_acc && pop_ch==push_ch)).
- push_ready equals push_acc evaluated with push forced to 1.
- Push writes mem[push_ch][tail] and advances tail.
- Pop advances head of pop_ch.
- Pop on an empty channel is never satisfied by a same-cycle push; there is no bypass.

**Count update per channel c**
- +1 if only a push is accepted on c.
- −1 if only a pop is accepted on c.
- Unchanged if both are accepted on c, or neither.

**Errors**
- push && !push_acc sets overflow_err; pop && !pop_acc sets underflow_err (enable=1, flush=0).
- Flags hold until err_clear=1 (enable=1) or reset.
- When err_clear and a new error occur in the same cycle, the new error wins (flag stays 1).

**Flush**
- Zeroes all heads, tails and counts.
- Same-cycle push and pop are ignored and raise no errors.

**Reset**
- Pointers, counts and error flags go to 0 immediately, even mid-operation.
- Outputs under reset: empty all-ones, almost_empty all-ones (AEMPTY_THRESH ≥ 0), full/almost_full all-zero (AFULL_THRESH ≥ 1), count 0, pop_valid 0, pop_tag 0, push_ready 1 whenever enable=1 and flush=0.

## Timing
- pop_valid, pop_tag and push_ready are combinational from current state and the pop_ch/push_ch/pop/enable/flush inputs.
- Pushed tag is visible at the head one cycle after acceptance (write-then-read latency 1).
- Pop takes effect at the clock edge; the next head appears the following cycle.
- Status and count outputs are decoded from registered counts and update the cycle after the accepting edge.
- Pointer wrap from DEPTH−1 to 0 needs no extra cycle.
- Sustained throughput: one push and one pop per cycle, on any channels.

## Test plan
- **Reset/idle:** deassert reset_n with enable=1 -> empty=all-ones, count=0, pop_valid=0, pop_tag=0, push_ready=1, both errors 0.
- **Fill, wrap and order on ch 2 (defaults):**
  - Push tags 0x10..0x17 -> count[2]=8, full[2]=1, almost_full[2]=1 after tag 6.
  - 9th push -> rejected, overflow_err=1.
  - 8 pops -> tags return 0x10..0x17 in order.
  - Push 0x20..0x23 -> pointers wrap cleanly, 0x20..0x23 returned in order.
- **Simultaneous push+pop:**
  - On full ch 1: push 0xAA with pop -> accepted, count stays 8, 0xAA is the last of the next 8 pops.
  - On empty ch 0: push+pop -> pop rejected, underflow_err=1, count[0]=1.
- **Channel isolation:** interleave pushes to ch 0 and ch 3 -> each channel pops only its own tags, counts independent.
- **Flush and enable:**
  - Flush with 5 tags in ch 2 and a same-cycle push -> all counts 0, no error set.
  - enable=0 with push/pop/err_clear active -> no state change.
- **Async reset mid-traffic:** assert reset_n low between edges during pushes -> outputs return to reset values without a clock; first push after release lands at head.

Source files
------------

// File: rtl/tag_fifo_mc.sv
// tag_fifo_mc: NUM_CH independent circular tag queues that share one push port
// and one pop port. Each port is steered by a channel index. Every channel has
// its own occupancy count, threshold status bits and wrap-around pointers.
// Sticky overflow/underflow flags record requests that could not be accepted.
module tag_fifo_mc #(
  parameter int NUM_CH        = 4,
  parameter int INDEX_BITS    = 3,
  parameter int DATA_WIDTH    = 256,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1,
  localparam int CH_BITS      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               flush,
  input  logic                               err_clear,
  input  logic                               push,
  input  logic [CH_BITS-1:0]                 push_ch,
  input  logic [DATA_WIDTH-1:0]              push_tag,
  output logic                               push_ready,
  input  logic                               pop,
  input  logic [CH_BITS-1:0]                 pop_ch,
  output logic                               pop_valid,
  output logic [DATA_WIDTH-1:0]              pop_tag,
  output logic [NUM_CH-1:0]                  full,
  output logic [NUM_CH-1:0]                  empty,
  output logic [NUM_CH-1:0]                  almost_full,
  output logic [NUM_CH-1:0]                  almost_empty,
  output logic [NUM_CH*(INDEX_BITS+1)-1:0]   count,
  output logic                               overflow_err,
  output logic                               underflow_err
);

  localparam int                DEPTH    = 1 << INDEX_BITS;
  localparam int                CW       = INDEX_BITS + 1;
  localparam logic [CW-1:0]     DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]     AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]     AEMPTY_C = CW'(AEMPTY_THRESH);
  localparam logic [CH_BITS:0]  NUM_CH_C = (CH_BITS + 1)'(NUM_CH);

  logic [DATA_WIDTH-1:0] mem      [NUM_CH][DEPTH];
  logic [INDEX_BITS-1:0] head_ptr [NUM_CH];
  logic [INDEX_BITS-1:0] tail_ptr [NUM_CH];
  logic [CW-1:0]         cnt      [NUM_CH];

  logic              active;
  logic              push_ch_ok;
  logic              pop_ch_ok;
  logic              pop_acc;
  logic              push_acc;
  logic              ovf_set;
  logic              unf_set;
  logic [NUM_CH-1:0] push_hit;
  logic [NUM_CH-1:0] pop_hit;

  // Accept decisions. The full-channel exception applies only when a pop on
  // the same channel frees a slot in this cycle. There is no empty-channel
  // bypass: a pop on an empty channel is rejected even if a push arrives.
  assign active     = enable & ~flush;
  assign push_ch_ok = {1'b0, push_ch} < NUM_CH_C;
  assign pop_ch_ok  = {1'b0, pop_ch} < NUM_CH_C;
  assign pop_valid  = pop_ch_ok & ~empty[pop_ch];
  assign pop_acc    = active & pop & pop_valid;
  assign push_ready = active & push_ch_ok &
                      (~full[push_ch] | (pop_acc & (pop_ch == push_ch)));
  assign push_acc   = push & push_ready;
  assign ovf_set    = active & push & ~push_acc;
  assign unf_set    = active & pop & ~pop_acc;
  assign pop_tag    = pop_valid ? mem[pop_ch][head_ptr[pop_ch]] : '0;

  // Decode per-channel status from the registered counts and steer the accepts.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    full         = '0;
    empty        = '0;
    almost_full  = '0;
    almost_empty = '0;
    count        = '0;
    push_hit     = '0;
    pop_hit      = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]              = (cnt[c] == DEPTH_C);
      empty[c]             = (cnt[c] == '0);
      almost_full[c]       = (cnt[c] >= AFULL_C);
      almost_empty[c]      = (cnt[c] <= AEMPTY_C);
      count[c*CW +: CW]    = cnt[c];
      push_hit[c]          = push_acc & (push_ch == CH_BITS'(c));
      pop_hit[c]           = pop_acc & (pop_ch == CH_BITS'(c));
    end
  end

  // Pointer and count state for each channel. Flush clears all channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        // NOTE: state registers use non-blocking assignments, so every register samples pre-edge values and the order of statements does not matter.
        head_ptr[c] <= '0;
        tail_ptr[c] <= '0;
        cnt[c]      <= '0;
      end
    end else if (enable) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          head_ptr[c] <= '0;
          tail_ptr[c] <= '0;
          cnt[c]      <= '0;
        end else begin
          if (push_hit[c]) tail_ptr[c] <= tail_ptr[c] + 1'b1;
          if (pop_hit[c])  head_ptr[c] <= head_ptr[c] + 1'b1;
          if (push_hit[c] && !pop_hit[c])      cnt[c] <= cnt[c] + 1'b1;
          else if (pop_hit[c] && !push_hit[c]) cnt[c] <= cnt[c] - 1'b1;
        end
      end
    end
  end

  // Sticky error flags. A new error in the same cycle takes priority over err_clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (enable) begin
      overflow_err  <= ovf_set | (overflow_err & ~err_clear);
      underflow_err <= unf_set | (underflow_err & ~err_clear);
    end
  end

  // Tag storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; pointers and counts define which entries are valid, so stale contents are never observed.
    if (push_acc) mem[push_ch][tail_ptr[push_ch]] <= push_tag;
  end

endmodule

// File: tb/tb_tag_fifo_mc.sv
// tb_tag_fifo_mc: directed and random stimulus for tag_fifo_mc. Expected
// values come from a reference model that keeps one ordered list of
// (channel, tag) entries.
module tb_tag_fifo_mc;

  localparam int NUM_CH     = 4;
  localparam int INDEX_BITS = 3;
  localparam int DATA_WIDTH = 256;
  localparam int DEPTH      = 8;
  localparam int CW         = INDEX_BITS + 1;
  localparam int AFULL_T    = 6;
  localparam int AEMPTY_T   = 1;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   enable;
  logic                   flush;
  logic                   err_clear;
  logic                   push;
  logic [1:0]             push_ch;
  logic [DATA_WIDTH-1:0]  push_tag;
  logic                   push_ready;
  logic                   pop;
  logic [1:0]             pop_ch;
  logic                   pop_valid;
  logic [DATA_WIDTH-1:0]  pop_tag;
  logic [NUM_CH-1:0]      full;
  logic [NUM_CH-1:0]      empty;
  logic [NUM_CH-1:0]      almost_full;
  logic [NUM_CH-1:0]      almost_empty;
  logic [NUM_CH*CW-1:0]   count;
  logic                   overflow_err;
  logic                   underflow_err;

  always #5 clk = ~clk;

  tag_fifo_mc #(
    .NUM_CH(NUM_CH), .INDEX_BITS(INDEX_BITS), .DATA_WIDTH(DATA_WIDTH),
    .AFULL_THRESH(AFULL_T), .AEMPTY_THRESH(AEMPTY_T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .err_clear(err_clear), .push(push), .push_ch(push_ch), .push_tag(push_tag),
    .push_ready(push_ready), .pop(pop), .pop_ch(pop_ch), .pop_valid(pop_valid),
    .pop_tag(pop_tag), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow_err(overflow_err),
    .underflow_err(underflow_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int                    ch;
    logic [DATA_WIDTH-1:0] tag;
  } ent_t;

  // Model state: all queued tags in arrival order, tagged with their channel.
  ent_t                  mq[$];
  logic                  m_ovf = 1'b0;
  logic                  m_unf = 1'b0;
  logic [DATA_WIDTH-1:0] seen_tag;

  task automatic check(input string tag, input logic [DATA_WIDTH-1:0] obs,
                       input logic [DATA_WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count(input int c);
    int n = 0;
    foreach (mq[i]) if (mq[i].ch == c) n++;
    return n;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] m_head(input int c);
    foreach (mq[i]) if (mq[i].ch == c) return mq[i].tag;
    return '0;
  endfunction

  task automatic m_pop(input int c);
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].ch == c) begin
        mq.delete(i);
        return;
      end
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int c);
    return count[c*CW +: CW];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rand_tag();
    logic [DATA_WIDTH-1:0] t;
    for (int w = 0; w < DATA_WIDTH / 32; w++) t[w*32 +: 32] = $urandom;
    return t;
  endfunction

  task automatic check_status();
    logic [NUM_CH*CW-1:0] ec;
    logic [NUM_CH-1:0]    ef, ee, eaf, eae;
    for (int c = 0; c < NUM_CH; c++) begin
      int n;
      n = m_count(c);
      ec[c*CW +: CW] = CW'(n);
      ef[c]  = (n == DEPTH);
      ee[c]  = (n == 0);
      eaf[c] = (n >= AFULL_T);
      eae[c] = (n <= AEMPTY_T);
    end
    check("count", count, ec);
    check("full", full, ef);
    check("empty", empty, ee);
    check("almost_full", almost_full, eaf);
    check("almost_empty", almost_empty, eae);
    check("overflow_err", overflow_err, m_ovf);
    check("underflow_err", underflow_err, m_unf);
  endtask

  // One clock cycle: check combinational outputs, clock, update model, check state.
  task automatic step();
    bit act, pa, pr, pu;
    #1;
    act = enable && !flush;
    pa  = act && pop && (m_count(int'(pop_ch)) > 0);
    pr  = act && ((m_count(int'(push_ch)) < DEPTH) || (pa && pop_ch == push_ch));
    pu  = push && pr;
    check("pop_valid", pop_valid, m_count(int'(pop_ch)) > 0);
    check("pop_tag", pop_tag, m_head(int'(pop_ch)));
    check("push_ready", push_ready, pr);
    seen_tag = pop_tag;
    @(posedge clk);
    if (enable) begin
      if (flush) mq.delete();
      else begin
        if (pa) m_pop(int'(pop_ch));
        if (pu) mq.push_back('{ch: int'(push_ch), tag: push_tag});
      end
      m_ovf = (act && push && !pu) ? 1'b1 : (err_clear ? 1'b0 : m_ovf);
      m_unf = (act && pop && !pa)  ? 1'b1 : (err_clear ? 1'b0 : m_unf);
    end
    #1;
    check_status();
  endtask

  task automatic cyc(input bit pu, input int pch, input logic [DATA_WIDTH-1:0] tag,
                     input bit po, input int qch);
    push     = pu;
    push_ch  = 2'(pch);
    push_tag = tag;
    pop      = po;
    pop_ch   = 2'(qch);
    step();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; flush = 1'b0; err_clear = 1'b0;
    push = 1'b0; push_ch = '0; push_tag = '0; pop = 1'b0; pop_ch = '0;

    // Reset / idle
    #12;
    check_status();
    check("rst_pop_valid", pop_valid, 1'b0);
    check("rst_pop_tag", pop_tag, '0);
    check("rst_push_ready", push_ready, 1'b1);
    #1 reset_n = 1'b1;

    // Fill channel 2 with 0x10..0x17, watching the almost-full threshold
    for (int i = 0; i < 8; i++) begin
      cyc(1, 2, DATA_WIDTH'(32'h10 + i), 0, 0);
      check("af2_thresh", almost_full[2], i >= AFULL_T - 1);
    end
    check("cnt2_full", cnt_of(2), 4'd8);
    check("full2", full[2], 1'b1);

    // Ninth push is rejected and raises overflow
    cyc(1, 2, DATA_WIDTH'(32'h18), 0, 0);
    check("ovf_on_full", overflow_err, 1'b1);
    err_clear = 1'b1;
    cyc(0, 0, '0, 0, 0);
    err_clear = 1'b0;
    check("ovf_cleared", overflow_err, 1'b0);

    // Drain channel 2 in order
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, '0, 1, 2);
      check("order_ch2", seen_tag, DATA_WIDTH'(32'h10 + i));
    end
    check("empty2", empty[2], 1'b1);

    // Pointer wrap
    for (int i = 0; i < 4; i++) cyc(1, 2, DATA_WIDTH'(32'h20 + i), 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, '0, 1, 2);
      check("wrap_ch2", seen_tag, DATA_WIDTH'(32'h20 + i));
    end

    // Push with same-channel pop on full channel 1
    for (int i = 0; i < 8; i++) cyc(1, 1, DATA_WIDTH'(32'h30 + i), 0, 0);
    cyc(1, 1, DATA_WIDTH'(32'hAA), 1, 1);
    check("full_pp_head", seen_tag, DATA_WIDTH'(32'h30));
    check("full_pp_cnt", cnt_of(1), 4'd8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, '0, 1, 1);
      check("full_pp_order", seen_tag,
            (i == 7) ? DATA_WIDTH'(32'hAA) : DATA_WIDTH'(32'h31 + i));
    end

    // Push with pop on empty channel 0: no bypass
    cyc(1, 0, DATA_WIDTH'(32'h55), 1, 0);
    check("unf_no_bypass", underflow_err, 1'b1);
    check("cnt0_one", cnt_of(0), 4'd1);
    err_clear = 1'b1;
    cyc(0, 0, '0, 1, 0);
    err_clear = 1'b0;
    check("unf_cleared", underflow_err, 1'b0);

    // Channel isolation between channels 0 and 3
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, DATA_WIDTH'(32'h40 + i), 0, 0);
      cyc(1, 3, DATA_WIDTH'(32'h50 + i), 0, 0);
    end
    check("iso_cnt0", cnt_of(0), 4'd3);
    check("iso_cnt3", cnt_of(3), 4'd3);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0, 1, 3);
      check("iso_ch3", seen_tag, DATA_WIDTH'(32'h50 + i));
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, '0, 1, 0);
      check("iso_ch0", seen_tag, DATA_WIDTH'(32'h40 + i));
    end

    // Flush with five tags in channel 2 and same-cycle push/pop
    for (int i = 0; i < 5; i++) cyc(1, 2, DATA_WIDTH'(32'h60 + i), 0, 0);
    flush = 1'b1;
    cyc(1, 2, DATA_WIDTH'(32'h99), 1, 2);
    flush = 1'b0;
    check("flush_count", count, '0);
    check("flush_no_ovf", overflow_err, 1'b0);
    check("flush_no_unf", underflow_err, 1'b0);

    // enable=0 freezes state, including err_clear
    cyc(0, 0, '0, 1, 1);
    cyc(1, 1, DATA_WIDTH'(32'h70), 0, 0);
    cyc(1, 1, DATA_WIDTH'(32'h71), 0, 0);
    enable = 1'b0; err_clear = 1'b1;
    cyc(1, 1, DATA_WIDTH'(32'hBB), 1, 1);
    enable = 1'b1; err_clear = 1'b0;
    check("en_cnt1", cnt_of(1), 4'd2);
    check("en_unf_held", underflow_err, 1'b1);

    // Asynchronous reset between edges while a push is pending
    push = 1'b1; push_ch = 2'd3; push_tag = DATA_WIDTH'(32'h66);
    pop = 1'b0; pop_ch = 2'd1;
    #3 reset_n = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    #1;
    check_status();
    check("arst_pop_valid", pop_valid, 1'b0);
    check("arst_pop_tag", pop_tag, '0);
    check("arst_push_ready", push_ready, 1'b1);
    push = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    cyc(1, 0, DATA_WIDTH'(32'h77), 0, 0);
    push = 1'b0; pop_ch = 2'd0;
    #1;
    check("arst_first_valid", pop_valid, 1'b1);
    check("arst_first_head", pop_tag, DATA_WIDTH'(32'h77));

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      enable    = ($urandom % 10) != 0;
      flush     = ($urandom % 40) == 0;
      err_clear = ($urandom % 16) == 0;
      cyc(($urandom % 4) != 0, int'($urandom % NUM_CH), rand_tag(),
          ($urandom % 3) != 0, int'($urandom % NUM_CH));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
